// File: rtl/host_io.sv
// Memory-mapped host peripheral: console TX FIFO, sticky exit latch, PC-stall watchdog, STATUS read-back.
// Reads answer one cycle after the request; a PUTC into a full FIFO holds wbusy high until a slot frees.
module host_io #(
    parameter logic [31:0] BASE       = 32'h9000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          TIMEOUT    = 100
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        wready,
    input  logic [31:0] waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        wbusy,
    output logic        whit,
    input  logic        rready,
    input  logic [31:0] raddr,
    output logic        rresp,
    output logic [31:0] rdata,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        done,
    output logic [31:0] exit_code,
    output logic        timeout
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [7:0] OFF_PUTC   = 8'h1C;
    localparam logic [7:0] OFF_STATUS = 8'h20;
    localparam logic [7:0] OFF_WDOG   = 8'h24;
    localparam logic [7:0] OFF_EXIT   = 8'h2C;

    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          wr_en;
    logic          putc_req;
    logic          wr_acc;
    logic          push;
    logic          pop;
    logic          exit_wr;
    logic          wdog_wr;
    logic          rd_hit;
    logic [15:0]   limit;
    logic [15:0]   cnt;
    logic [31:0]   prev_pc;
    logic [31:0]   status;

    assign whit     = wready && (waddr[31:8] == BASE[31:8]);
    assign wr_en    = whit && (wstrb != 4'h0);
    assign putc_req = wr_en && (waddr[7:0] == OFF_PUTC);
    // Busy ignores a same-cycle pop so the push never races the drain.
    assign wbusy    = putc_req && full;
    assign wr_acc   = wr_en && !wbusy;
    assign push     = wr_acc && (waddr[7:0] == OFF_PUTC);
    assign exit_wr  = wr_acc && (waddr[7:0] == OFF_EXIT);
    assign wdog_wr  = wr_acc && (waddr[7:0] == OFF_WDOG);

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
    assign pop      = tx_valid && tx_ready;

    assign rd_hit   = rready && (raddr[31:8] == BASE[31:8]);
    assign status   = {16'h0000, 8'(count), 4'h0, timeout, done, full, empty};

    always_ff @(posedge clk) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            done      <= 1'b0;
            exit_code <= 32'h0;
        end else if (exit_wr && !done) begin
            done      <= 1'b1;
            exit_code <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            prev_pc <= 32'h0;
            cnt     <= 16'h0;
            limit   <= 16'(TIMEOUT);
            timeout <= 1'b0;
        end else begin
            if (pc_valid) prev_pc <= pc_in;
            if (wdog_wr) begin
                limit <= wdata[15:0];
                cnt   <= 16'h0;
            end else if (pc_valid) begin
                if (pc_in != prev_pc)   cnt <= 16'h0;
                else if (cnt != 16'hFFFF) cnt <= cnt + 16'h1;
            end
            if ((limit != 16'h0) && (cnt == limit)) timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            rresp <= 1'b0;
            rdata <= 32'h0;
        end else begin
            rresp <= rd_hit;
            rdata <= (rd_hit && (raddr[7:0] == OFF_STATUS)) ? status : 32'h0;
        end
    end
endmodule

// File: tb/tb_host_io.sv
// Directed bench for host_io: stimulus pushes expected TX bytes and read data into queues; a monitor pops and compares.
module tb_host_io;
    localparam logic [31:0] B = 32'h9000_0000;

    logic        clk = 1'b0;
    logic        resetb;
    logic        wready;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wbusy;
    logic        whit;
    logic        rready;
    logic [31:0] raddr;
    logic        rresp;
    logic [31:0] rdata;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        done;
    logic [31:0] exit_code;
    logic        timeout;

    always #5 clk = ~clk;

    host_io dut (
        .clk(clk), .resetb(resetb),
        .wready(wready), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .wbusy(wbusy), .whit(whit),
        .rready(rready), .raddr(raddr), .rresp(rresp), .rdata(rdata),
        .pc_in(pc_in), .pc_valid(pc_valid),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .done(done), .exit_code(exit_code), .timeout(timeout)
    );

    int checks = 0;
    int passed = 0;
    logic [7:0]  exp_tx [$];
    logic [31:0] exp_rd [$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endfunction

    function automatic void fail(string name);
        checks++;
        $display("FAIL %s: event not seen within bound", name);
    endfunction

    // Monitor: every visible TX handshake and read response is matched against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    $display("FAIL tx_extra: got byte 0x%02h, want none", tx_data);
                end else check("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
            end
            if (rresp === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    $display("FAIL rd_extra: got rdata 0x%08h, want no response", rdata);
                end else check("rd_data", rdata, exp_rd.pop_front());
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        wready = 1'b1; waddr = B + 32'(off); wdata = d; wstrb = 4'hF;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!wbusy) begin
                tick();
                wready = 1'b0; wstrb = 4'h0;
                return;
            end
            tick();
        end
        fail("wr_accept");
        wready = 1'b0; wstrb = 4'h0;
    endtask

    task automatic putc(input logic [7:0] b);
        exp_tx.push_back(b);
        wr(8'h1C, {24'hABCDEF, b});
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp);
        rready = 1'b1; raddr = B + 32'(off);
        exp_rd.push_back(exp);
        tick();
        rready = 1'b0;
    endtask

    task automatic drain();
        tx_ready = 1'b1;
        for (int i = 0; i < 60 && exp_tx.size() != 0; i++) tick();
        tick(2);
        check("drain_queue", 32'(exp_tx.size()), 32'd0);
        check("drain_tx_valid", {31'h0, tx_valid}, 32'd0);
    endtask

    initial begin
        resetb = 1'b0; wready = 1'b0; waddr = 32'h0; wdata = 32'h0; wstrb = 4'h0;
        rready = 1'b0; raddr = 32'h0; pc_in = 32'h0; pc_valid = 1'b0; tx_ready = 1'b0;
        tick(2);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'h0, tx_data}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_exit_code", exit_code, 32'd0);
        check("rst_timeout", {31'h0, timeout}, 32'd0);
        check("rst_rresp", {31'h0, rresp}, 32'd0);
        resetb = 1'b1;

        // Window decode is combinational.
        wready = 1'b1; waddr = B + 32'h1C; #1;
        check("whit_in", {31'h0, whit}, 32'd1);
        waddr = 32'h8000_001C; #1;
        check("whit_out", {31'h0, whit}, 32'd0);
        wready = 1'b0; tick();

        // Two bytes stream straight through.
        tx_ready = 1'b1;
        putc(8'h41);
        putc(8'h42);
        tick(3);
        check("tx_idle", {31'h0, tx_valid}, 32'd0);
        rd(8'h20, 32'h0000_0001);
        tick(2);

        // Fill the FIFO, hold the 17th write until one slot frees.
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) putc(8'(i));
        exp_tx.push_back(8'd16);
        wready = 1'b1; waddr = B + 32'h1C; wdata = 32'd16; wstrb = 4'hF;
        rready = 1'b1; raddr = B + 32'h20;
        exp_rd.push_back(32'h0000_1002);
        @(negedge clk); check("wbusy_full", {31'h0, wbusy}, 32'd1);
        tick(); rready = 1'b0;
        @(negedge clk); check("wbusy_held", {31'h0, wbusy}, 32'd1);
        tick(); tx_ready = 1'b1;
        @(negedge clk); check("wbusy_pop_cycle", {31'h0, wbusy}, 32'd1);
        tick(); tx_ready = 1'b0;
        @(negedge clk); check("wbusy_freed", {31'h0, wbusy}, 32'd0);
        tick(); wready = 1'b0; wstrb = 4'h0;
        rd(8'h20, 32'h0000_1002);
        drain();

        // Exit code latches once; console keeps working afterwards.
        wr(8'h2C, 32'h0000_0007);
        check("exit_done", {31'h0, done}, 32'd1);
        check("exit_code_first", exit_code, 32'h7);
        wr(8'h2C, 32'h0000_0009);
        check("exit_done_sticky", {31'h0, done}, 32'd1);
        check("exit_code_kept", exit_code, 32'h7);
        rd(8'h20, 32'h0000_0005);
        rd(8'h00, 32'h0000_0000);
        rready = 1'b1; raddr = 32'h8000_0020; tick(); rready = 1'b0;
        @(negedge clk);
        check("miss_rresp", {31'h0, rresp}, 32'd0);
        check("miss_rdata", rdata, 32'd0);
        tick();
        putc(8'h55);
        drain();

        // Default limit 100: a PC change and a pc_valid gap in the middle.
        pc_in = 32'h100; pc_valid = 1'b1;
        tick(50);
        check("wd_partial", {31'h0, timeout}, 32'd0);
        pc_in = 32'h104; tick();
        pc_valid = 1'b0; pc_in = 32'h200; tick(30);
        check("wd_gap", {31'h0, timeout}, 32'd0);
        pc_valid = 1'b1; pc_in = 32'h104;
        tick(100);
        check("wd_at_limit", {31'h0, timeout}, 32'd0);
        tick();
        check("wd_fired", {31'h0, timeout}, 32'd1);
        rd(8'h20, 32'h0000_000D);
        pc_valid = 1'b0;

        // Reset, disable the watchdog, then re-arm with limit 5.
        resetb = 1'b0; tick(); resetb = 1'b1;
        check("rst2_timeout", {31'h0, timeout}, 32'd0);
        wr(8'h24, 32'h0);
        pc_in = 32'h300; pc_valid = 1'b1;
        tick(1000);
        check("wd_disabled", {31'h0, timeout}, 32'd0);
        wr(8'h24, 32'h5);
        tick(5);
        check("wd5_before", {31'h0, timeout}, 32'd0);
        tick();
        check("wd5_fired", {31'h0, timeout}, 32'd1);
        pc_valid = 1'b0;

        // Reset mid-drain drops FIFO contents, flags and a coincident read.
        wr(8'h2C, 32'h11);
        tx_ready = 1'b0;
        putc(8'hA1); putc(8'hA2); putc(8'hA3);
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        resetb = 1'b0; rready = 1'b1; raddr = B + 32'h20;
        tick();
        resetb = 1'b1; rready = 1'b0;
        exp_tx.delete();
        check("mid_tx_valid", {31'h0, tx_valid}, 32'd0);
        check("mid_done", {31'h0, done}, 32'd0);
        check("mid_timeout", {31'h0, timeout}, 32'd0);
        check("mid_exit_code", exit_code, 32'd0);
        @(negedge clk);
        check("mid_rresp", {31'h0, rresp}, 32'd0);
        tick();
        rd(8'h20, 32'h0000_0001);
        tick(3);

        check("end_rd_queue", 32'(exp_rd.size()), 32'd0);
        check("end_tx_queue", 32'(exp_tx.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
